// File: rtl/div_issue_ctrl.sv
// rtl/div_issue_ctrl.sv - IDIV request screening, divider core sequencing and response holding
module div_issue_ctrl #(
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 48
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_dividend,
  input  logic [31:0]      req_divisor,
  input  logic [TAG_W-1:0] req_tag,
  output logic             div_start,
  output logic [31:0]      div_dividend,
  output logic [31:0]      div_divisor,
  input  logic             div_busy,
  input  logic             div_over,
  input  logic [31:0]      div_q,
  input  logic [31:0]      div_r,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_q,
  output logic [31:0]      rsp_r,
  output logic [1:0]       rsp_err,
  output logic [TAG_W-1:0] rsp_tag
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_BUSY,
    WAIT_DONE,
    RESP
  } state_t;

  localparam logic [31:0] INT_MIN  = 32'h8000_0000;
  localparam logic [31:0] NEG_ONE  = 32'hFFFF_FFFF;
  localparam logic [7:0]  WDOG_MAX = 8'(TIMEOUT);

  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_DZ   = 2'b01;
  localparam logic [1:0] ERR_OVF  = 2'b10;
  localparam logic [1:0] ERR_TOUT = 2'b11;

  state_t     state;
  logic [7:0] wdog;

  // Ready is a pure decode of IDLE, forced low while reset is asserted.
  assign req_ready = reset_n && (state == IDLE);

  // Main sequencer: screening, start pulse, busy/over tracking, watchdog and held response.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      wdog         <= 8'd0;
      div_start    <= 1'b0;
      div_dividend <= 32'd0;
      div_divisor  <= 32'd0;
      rsp_valid    <= 1'b0;
      rsp_q        <= 32'd0;
      rsp_r        <= 32'd0;
      rsp_err      <= ERR_OK;
      rsp_tag      <= '0;
    end else begin
      div_start <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            div_dividend <= req_dividend;
            div_divisor  <= req_divisor;
            rsp_tag      <= req_tag;
            rsp_q        <= 32'd0;
            rsp_r        <= 32'd0;
            rsp_err      <= ERR_OK;
            if (req_divisor == 32'd0) begin
              rsp_err   <= ERR_DZ;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else if (req_dividend == INT_MIN && req_divisor == NEG_ONE) begin
              rsp_err   <= ERR_OVF;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else if (req_divisor == 32'd1) begin
              rsp_q     <= req_dividend;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else if (req_divisor == NEG_ONE) begin
              rsp_q     <= 32'd0 - req_dividend;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else begin
              div_start <= 1'b1;
              state     <= START;
            end
          end
        end
        START: begin
          wdog  <= 8'd0;
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (wdog == WDOG_MAX) begin
            rsp_err   <= ERR_TOUT;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            wdog <= wdog + 8'd1;
            if (div_busy) state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          // Completion is checked before expiry so a same-cycle finish reports ok.
          if (!div_busy && div_over) begin
            rsp_q     <= div_q;
            rsp_r     <= div_r;
            rsp_err   <= ERR_OK;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else if (wdog == WDOG_MAX) begin
            rsp_err   <= ERR_TOUT;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            wdog <= wdog + 8'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// tb/tb_div_issue_ctrl.sv - self-checking bench for div_issue_ctrl with a behavioural divider core
module tb_div_issue_ctrl;

  localparam int TAG_W   = 4;
  localparam int TIMEOUT = 48;

  logic             clock = 1'b0;
  logic             reset_n = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [31:0]      req_dividend = '0;
  logic [31:0]      req_divisor = '0;
  logic [TAG_W-1:0] req_tag = '0;
  logic             div_start;
  logic [31:0]      div_dividend;
  logic [31:0]      div_divisor;
  logic             div_busy;
  logic             div_over;
  logic [31:0]      div_q;
  logic [31:0]      div_r;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [31:0]      rsp_q;
  logic [31:0]      rsp_r;
  logic [1:0]       rsp_err;
  logic [TAG_W-1:0] rsp_tag;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int nstart = 0;
  bit hang  = 1'b0;

  div_issue_ctrl #(.TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor), .req_tag(req_tag),
    .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_busy(div_busy), .div_over(div_over), .div_q(div_q), .div_r(div_r),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_q(rsp_q), .rsp_r(rsp_r), .rsp_err(rsp_err), .rsp_tag(rsp_tag)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) if (reset_n && div_start) nstart++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  // Behavioural divider core: busy the cycle after start, 33 busy cycles, sticky over.
  int core_cnt;
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      div_busy <= 1'b0; div_over <= 1'b0; div_q <= '0; div_r <= '0; core_cnt <= 0;
    end else if (div_start) begin
      div_busy <= 1'b1; div_over <= 1'b0; core_cnt <= 33;
    end else if (div_busy && !hang) begin
      core_cnt <= core_cnt - 1;
      if (core_cnt == 1) begin
        div_busy <= 1'b0;
        div_over <= 1'b1;
        div_q    <= 32'($signed(div_dividend) / $signed(div_divisor));
        div_r    <= 32'($signed(div_dividend) % $signed(div_divisor));
      end
    end
  end

  // Transaction-level reference: what one request must produce and when.
  bit          m_act = 1'b0;
  bit          m_core;
  int          m_acc, m_lat, m_rel;
  logic [31:0] m_q, m_r, m_dd, m_dv;
  logic [1:0]  m_err;
  logic [TAG_W-1:0] m_tag;

  task automatic model_accept(input logic [31:0] dd, input logic [31:0] dv, input logic [TAG_W-1:0] tg);
    int sdd, sdv;
    sdd = dd; sdv = dv;
    m_dd = dd; m_dv = dv; m_tag = tg;
    m_core = !(dv == 32'd0 || dv == 32'd1 || dv == 32'hFFFF_FFFF);
    m_q = '0; m_r = '0;
    if (dv == 32'd0) m_err = 2'b01;
    else if (dd == 32'h8000_0000 && dv == 32'hFFFF_FFFF) m_err = 2'b10;
    else if (m_core && hang) m_err = 2'b11;
    else begin
      m_err = 2'b00;
      m_q = 32'(sdd / sdv);
      m_r = 32'(sdd % sdv);
    end
    m_lat = !m_core ? 1 : (hang ? TIMEOUT + 3 : 36);
  endtask

  // Single compare process: reset values, idle behaviour and the in-flight timeline.
  always @(negedge clock) begin
    if (!reset_n) begin
      m_act = 1'b0;
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_div_start", div_start, 0);
      chk("rst_rsp_q", rsp_q, 0);
      chk("rst_rsp_r", rsp_r, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_rsp_tag", rsp_tag, 0);
      chk("rst_div_dividend", div_dividend, 0);
      chk("rst_div_divisor", div_divisor, 0);
    end else if (!m_act) begin
      chk("idle_req_ready", req_ready, 1);
      chk("idle_rsp_valid", rsp_valid, 0);
      chk("idle_div_start", div_start, 0);
      if (req_valid) begin
        m_act = 1'b1;
        m_acc = cyc;
        model_accept(req_dividend, req_divisor, req_tag);
      end
    end else begin
      m_rel = cyc - m_acc;
      chk("busy_req_ready", req_ready, 0);
      chk("div_start", div_start, (m_core && m_rel == 1) ? 1 : 0);
      chk("rsp_valid", rsp_valid, (m_rel >= m_lat) ? 1 : 0);
      chk("div_dividend", div_dividend, m_dd);
      chk("div_divisor", div_divisor, m_dv);
      if (m_rel >= m_lat) begin
        chk("rsp_q", rsp_q, m_q);
        chk("rsp_r", rsp_r, m_r);
        chk("rsp_err", rsp_err, m_err);
        chk("rsp_tag", rsp_tag, m_tag);
        if (rsp_ready) m_act = 1'b0;
      end
    end
  end

  // Issue one request and check the response against hand-computed literals.
  task automatic run(input string nm, input logic [31:0] dd, input logic [31:0] dv,
                     input logic [TAG_W-1:0] tg, input bit hg, input int hold,
                     input logic [31:0] xq, input logic [31:0] xr, input logic [1:0] xe,
                     input int xlat, input int xstarts);
    int a, s0, n;
    bit got;
    @(posedge clock); #1;
    hang = hg;
    req_valid = 1'b1; req_dividend = dd; req_divisor = dv; req_tag = tg;
    got = 1'b0;
    for (n = 0; n < 10 && !got; n++) begin
      @(negedge clock);
      got = req_ready;
    end
    a  = cyc;
    s0 = nstart;
    @(posedge clock); #1;
    req_valid = 1'b0;
    req_dividend = $urandom; req_divisor = $urandom; req_tag = TAG_W'($urandom);
    got = 1'b0;
    for (n = 0; n < 200 && !got; n++) begin
      @(negedge clock);
      got = rsp_valid;
    end
    chk({nm, "_rsp_seen"}, got, 1);
    chk({nm, "_latency"}, cyc - a, xlat);
    chk({nm, "_q"}, rsp_q, xq);
    chk({nm, "_r"}, rsp_r, xr);
    chk({nm, "_err"}, rsp_err, xe);
    chk({nm, "_tag"}, rsp_tag, tg);
    repeat (hold) @(negedge clock);
    chk({nm, "_held_valid"}, rsp_valid, 1);
    chk({nm, "_held_q"}, rsp_q, xq);
    @(posedge clock); #1;
    rsp_ready = 1'b1;
    @(posedge clock); #1;
    rsp_ready = 1'b0;
    chk({nm, "_starts"}, nstart - s0, xstarts);
  endtask

  initial begin
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    repeat (2) @(posedge clock);

    run("basic",   32'd100,        32'd7,          4'h1, 0, 0, 32'h0000_000E, 32'h0000_0002, 2'b00, 36, 1);
    run("negdd",   32'hFFFF_FF9C,  32'd7,          4'h2, 0, 0, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 2'b00, 36, 1);
    run("negdv",   32'd100,        32'hFFFF_FFF9,  4'h3, 0, 0, 32'hFFFF_FFF2, 32'h0000_0002, 2'b00, 36, 1);
    run("dz",      32'd123,        32'd0,          4'h4, 0, 0, 32'h0,         32'h0,         2'b01, 1,  0);
    run("ovf",     32'h8000_0000,  32'hFFFF_FFFF,  4'h5, 0, 0, 32'h0,         32'h0,         2'b10, 1,  0);
    run("div1",    32'h8000_0000,  32'd1,          4'h6, 0, 0, 32'h8000_0000, 32'h0,         2'b00, 1,  0);
    run("divm1",   32'd5,          32'hFFFF_FFFF,  4'h7, 0, 0, 32'hFFFF_FFFB, 32'h0,         2'b00, 1,  0);
    run("bp",      32'd1000,       32'd3,          4'hA, 0, 10, 32'h0000_014D, 32'h0000_0001, 2'b00, 36, 1);
    run("hang",    32'd77,         32'd5,          4'hB, 1, 0, 32'h0,         32'h0,         2'b11, TIMEOUT + 3, 1);
    run("after",   32'd77,         32'd5,          4'hC, 0, 0, 32'h0000_000F, 32'h0000_0002, 2'b00, 36, 1);

    // Reset pulsed while the core is mid-division: no response may appear afterwards.
    @(posedge clock); #1;
    req_valid = 1'b1; req_dividend = 32'd50; req_divisor = 32'd6; req_tag = 4'hD;
    @(posedge clock); #1;
    req_valid = 1'b0;
    repeat (12) @(posedge clock);
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    repeat (45) @(negedge clock);
    chk("post_reset_no_rsp", rsp_valid, 0);
    chk("post_reset_ready", req_ready, 1);

    run("postrst", 32'hFFFF_FFF9,  32'd2,          4'hE, 0, 0, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 2'b00, 36, 1);

    repeat (3) @(posedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
